sram_col_ctrl: RTL and testbench

Single-port SRAM access sequencer for the configurable-width column path. It accepts read/write requests over a valid/ready handshake and sequences the macro through precharge and wordline/sense phases. It drives the per-access bitline mask for the current word-width configuration, aligns write data into the 32-bit row, and returns right-aligned read data. It sits between the core-side request port and the SRAM macro plus its bitline-mask logic.

---
 rtl/sram_col_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sram_col_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_col_ctrl.sv
// SRAM column-path access sequencer: accepts one read or write at a time and walks
// the macro through precharge and wordline/sense phases. It drives the bitline mask
// for the configured word width, aligns write data into the row and right-aligns read data.
module sram_col_ctrl #(
    parameter int unsigned ROW_W   = 6,
    parameter int unsigned PRE_CYC = 1,
    parameter int unsigned WL_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_conf,
    output logic             cfg_err,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ROW_W-1:0] req_row,
    input  logic [4:0]       req_col,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             sram_pre,
    output logic             sram_wl_en,
    output logic             sram_we,
    output logic             sram_sae,
    output logic [ROW_W-1:0] sram_row,
    output logic [31:0]      sram_bl_mask,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata
);

    localparam int unsigned MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StWl,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         conf_q;
    logic [2:0]         conf_lat_q;
    logic               cfg_err_q;
    logic [ROW_W-1:0]   row_q;
    logic [4:0]         col_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;

    logic               accept;
    logic               wl_last;
    logic               rd_sample;
    logic [5:0]         width;
    logic [4:0]         base;
    logic [31:0]        low_mask;
    logic [31:0]        row_mask;
    logic [31:0]        wdata_al;
    logic [31:0]        rdata_al;

    // Width decode from the per-access conf snapshot; conf=5 needs a special case
    // because a 32-bit shift of 1 would overflow.
    always_comb begin
        width    = 6'd1 << conf_lat_q;
        base     = col_q & ~5'(width - 6'd1);
        low_mask = (conf_lat_q == 3'd5) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        row_mask = low_mask << base;
        wdata_al = (wdata_q & low_mask) << base;
        rdata_al = (sram_rdata >> base) & low_mask;
    end

    // Next-state and output decode; every output is forced low while rst is high.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = 32'd0;
        sram_pre     = 1'b0;
        sram_wl_en   = 1'b0;
        sram_we      = 1'b0;
        sram_sae     = 1'b0;
        sram_bl_mask = 32'd0;
        sram_wdata   = 32'd0;
        wl_last      = (cnt_q == CNT_W'(WL_CYC - 1));
        cfg_err      = cfg_err_q & ~rst;
        sram_row     = rst ? '0 : row_q;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = StPre;
                    cnt_d   = '0;
                end
            end
            StPre: begin
                sram_pre = 1'b1;
                if (cnt_q == CNT_W'(PRE_CYC - 1)) begin
                    state_d = StWl;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWl: begin
                sram_wl_en   = 1'b1;
                sram_bl_mask = row_mask;
                sram_wdata   = wdata_al;
                sram_we      = we_q;
                sram_sae     = wl_last & ~we_q;
                if (wl_last) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst) begin
            req_ready    = 1'b0;
            resp_valid   = 1'b0;
            resp_rdata   = 32'd0;
            sram_pre     = 1'b0;
            sram_wl_en   = 1'b0;
            sram_we      = 1'b0;
            sram_sae     = 1'b0;
            sram_bl_mask = 32'd0;
            sram_wdata   = 32'd0;
        end
    end

    assign accept    = req_valid & req_ready;
    assign rd_sample = (state_q == StWl) & wl_last & ~we_q;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Width configuration register; illegal codes are dropped and flagged for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            conf_q    <= 3'd5;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we & (cfg_conf > 3'd5);
            if (cfg_we && cfg_conf <= 3'd5) begin
                conf_q <= cfg_conf;
            end
        end
    end

    // Request capture on acceptance, and read data capture at the end of the sense cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            col_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            conf_lat_q <= 3'd5;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                row_q      <= req_row;
                col_q      <= req_col;
                we_q       <= req_we;
                wdata_q    <= req_wdata;
                conf_lat_q <= conf_q;
                rdata_q    <= '0;
            end
            if (rd_sample) begin
                rdata_q <= rdata_al;
            end
        end
    end

endmodule

// File: tb/tb_sram_col_ctrl.sv
// Self-checking bench for sram_col_ctrl: directed scenarios plus randomized accesses
// checked against a bit-level behavioural model of the width/alignment rules.
module tb_sram_col_ctrl;

    localparam int unsigned ROW_W   = 6;
    localparam int unsigned PRE_CYC = 1;
    localparam int unsigned WL_CYC  = 2;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [2:0]       cfg_conf;
    logic             cfg_err;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ROW_W-1:0] req_row;
    logic [4:0]       req_col;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_rdata;
    logic             sram_pre;
    logic             sram_wl_en;
    logic             sram_we;
    logic             sram_sae;
    logic [ROW_W-1:0] sram_row;
    logic [31:0]      sram_bl_mask;
    logic [31:0]      sram_wdata;
    logic [31:0]      sram_rdata;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int model_conf = 5;
    int last_acc = 0;

    sram_col_ctrl #(
        .ROW_W  (ROW_W),
        .PRE_CYC(PRE_CYC),
        .WL_CYC (WL_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_conf    (cfg_conf),
        .cfg_err     (cfg_err),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_row     (req_row),
        .req_col     (req_col),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .sram_pre    (sram_pre),
        .sram_wl_en  (sram_wl_en),
        .sram_we     (sram_we),
        .sram_sae    (sram_sae),
        .sram_row    (sram_row),
        .sram_bl_mask(sram_bl_mask),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: a word of 2^c bits lives at the aligned slot containing col.
    function automatic logic [31:0] m_mask(input int c, input int col);
        int w = 1 << c;
        int b = (col / w) * w;
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) if (i >= b && i < b + w) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input int c, input int col, input logic [31:0] wd);
        int w = 1 << c;
        int b = (col / w) * w;
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) if (i >= b && i < b + w) m[i] = wd[i-b];
        return m;
    endfunction

    function automatic logic [31:0] m_rdata(input int c, input int col, input logic [31:0] rd);
        int w = 1 << c;
        int b = (col / w) * w;
        logic [31:0] r = '0;
        for (int j = 0; j < w; j++) r[j] = rd[b+j];
        return r;
    endfunction

    task automatic chk_idle_ctrl(input string tag);
        chk({tag, "_pre"}, 32'(sram_pre), 32'd0);
        chk({tag, "_wl"}, 32'(sram_wl_en), 32'd0);
        chk({tag, "_we"}, 32'(sram_we), 32'd0);
        chk({tag, "_sae"}, 32'(sram_sae), 32'd0);
        chk({tag, "_mask"}, sram_bl_mask, 32'd0);
        chk({tag, "_wdata"}, sram_wdata, 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic cfg_write(input int v);
        cfg_we   = 1'b1;
        cfg_conf = 3'(v);
        step();
        cfg_we = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err), (v > 5) ? 32'd1 : 32'd0);
        if (v <= 5) model_conf = v;
        step();
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    endtask

    // One complete access; optional cfg write overlapping acceptance and the first PRE cycle.
    task automatic access(input logic we, input int row, input int col, input logic [31:0] wd,
                          input logic [31:0] rd, input int stall, input int mid_cfg);
        int c = model_conf;
        logic [31:0] exp_r = we ? 32'd0 : m_rdata(c, col, rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_row    = ROW_W'(row);
        req_col    = 5'(col);
        req_wdata  = wd;
        sram_rdata = rd;
        resp_ready = 1'b0;
        if (mid_cfg >= 0) begin
            cfg_we   = 1'b1;
            cfg_conf = 3'(mid_cfg);
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        last_acc = cycle;
        step();
        req_valid = 1'b0;
        req_wdata = ~wd;
        req_col   = ~5'(col);
        for (int p = 0; p < int'(PRE_CYC); p++) begin
            chk("pre_on", 32'(sram_pre), 32'd1);
            chk("pre_wl_off", 32'(sram_wl_en), 32'd0);
            chk("pre_req_ready", 32'(req_ready), 32'd0);
            if (p == 0 && mid_cfg >= 0) begin
                if (mid_cfg <= 5) model_conf = mid_cfg;
            end
            step();
            cfg_we = 1'b0;
        end
        for (int k = 0; k < int'(WL_CYC); k++) begin
            chk("wl_on", 32'(sram_wl_en), 32'd1);
            chk("wl_pre_off", 32'(sram_pre), 32'd0);
            chk("wl_mask", sram_bl_mask, m_mask(c, col));
            chk("wl_row", 32'(sram_row), 32'(row));
            chk("wl_we", 32'(sram_we), 32'(we));
            chk("wl_sae", 32'(sram_sae), (!we && k == int'(WL_CYC) - 1) ? 32'd1 : 32'd0);
            if (we) chk("wl_wdata", sram_wdata, m_wdata(c, col, wd));
            chk("wl_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        chk("resp_latency", 32'(cycle - last_acc), 32'(PRE_CYC + WL_CYC + 1));
        sram_rdata = $urandom;
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata", resp_rdata, exp_r);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_wl_off", 32'(sram_wl_en), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, exp_r);
        step();
        resp_ready = 1'b0;
        chk("after_resp_valid", 32'(resp_valid), 32'd0);
        chk("after_resp_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int a0;
        int a1;
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_conf   = 3'd0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_row    = '0;
        req_col    = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        sram_rdata = '0;

        // Reset: everything low while rst is high, req_ready rises right after.
        step();
        step();
        chk_idle_ctrl("rst");
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_row", 32'(sram_row), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Default width is 32 bits: full mask and full read data.
        access(1'b0, 3, 21, 32'h0, 32'hDEAD_BEEF, 0, -1);

        // Narrow write and narrow read.
        cfg_write(2);
        access(1'b1, 7, 21, 32'h0000_000A, 32'h0, 0, -1);
        cfg_write(3);
        access(1'b0, 9, 21, 32'h0, 32'h1234_5678, 0, -1);

        // Width extremes.
        cfg_write(0);
        access(1'b0, 1, 21, 32'h0, 32'h0020_0000, 0, -1);
        access(1'b1, 1, 21, 32'hFFFF_FFFF, 32'h0, 0, -1);
        cfg_write(5);
        access(1'b0, 2, 21, 32'h0, 32'hCAFE_F00D, 0, -1);

        // Illegal config leaves width unchanged; cfg during an access affects only later ones.
        cfg_write(3);
        cfg_write(6);
        access(1'b0, 4, 13, 32'h0, 32'hA5C3_96F0, 0, -1);
        cfg_write(7);
        access(1'b0, 5, 6, 32'h0, 32'h89AB_CDEF, 0, 1);
        access(1'b0, 5, 6, 32'h0, 32'h89AB_CDEF, 0, -1);

        // Response stall of three cycles.
        access(1'b0, 6, 3, 32'h0, 32'h7654_3210, 3, -1);

        // Back-to-back accesses with resp_ready high: one every PRE+WL+2 cycles.
        access(1'b1, 10, 4, 32'h3, 32'h0, 0, -1);
        a0 = last_acc;
        access(1'b0, 11, 5, 32'h0, 32'hFFFF_0000, 0, -1);
        a1 = last_acc;
        chk("b2b_gap_1", 32'(a1 - a0), 32'(PRE_CYC + WL_CYC + 2));
        access(1'b1, 12, 6, 32'h1, 32'h0, 0, -1);
        chk("b2b_gap_2", 32'(last_acc - a1), 32'(PRE_CYC + WL_CYC + 2));

        // Reset mid-WL of a write aborts it and restores 32-bit width.
        cfg_write(2);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_row   = 6'd33;
        req_col   = 5'd8;
        req_wdata = 32'hF;
        step();
        req_valid = 1'b0;
        for (int p = 0; p < int'(PRE_CYC); p++) step();
        chk("abort_in_wl", 32'(sram_wl_en), 32'd1);
        rst = 1'b1;
        step();
        chk_idle_ctrl("abort1");
        chk("abort1_ready", 32'(req_ready), 32'd0);
        step();
        chk_idle_ctrl("abort2");
        rst = 1'b0;
        model_conf = 5;
        step();
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        access(1'b0, 20, 21, 32'h0, 32'h0BAD_F00D, 0, -1);

        // Randomized accesses against the model.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(int'($urandom_range(0, 7)));
            access(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 31)), $urandom, $urandom,
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
